// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: splits a round-robin 4-channel bit stream into
// four parallel WIDTH-bit words, aligned by a frame-sync marker.
module tdm_demux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_din,
  input  logic               i_din_valid,
  input  logic               i_frame_sync,
  output logic [1:0]         o_sel,
  output logic               o_locked,
  output logic [4*WIDTH-1:0] o_out_data,
  output logic               o_out_valid,
  output logic               o_sync_err
);

  localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned LAST_IDX = WIDTH - 1;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sel;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_locked;
  logic [WIDTH-1:0]     r_sh0;
  logic [WIDTH-1:0]     r_sh1;
  logic [WIDTH-1:0]     r_sh2;
  logic [WIDTH-2:0]     r_sh3;
  logic [4*WIDTH-1:0]   r_out_data;
  logic                 r_out_valid;
  logic                 r_sync_err;

  logic                 w_frame_start;
  logic                 w_last_bit;
  logic [WIDTH-1:0]     w_ch3_word;

  // Words fill MSB-first by right shift, so after WIDTH accepted bits the
  // first (LSB) bit sits at position 0. Channel 3 keeps WIDTH-1 bits because
  // its final bit goes straight from i_din into out_data.
  assign w_frame_start = (r_sel == 2'd0) && (r_idx == '0);
  assign w_last_bit    = (r_sel == 2'd3) && (r_idx == IDX_W'(LAST_IDX));
  assign w_ch3_word    = {i_din, r_sh3};

  // Single-process HUNT/RUN controller with registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= HUNT;
      r_sel       <= 2'd0;
      r_idx       <= '0;
      r_locked    <= 1'b0;
      r_sh0       <= '0;
      r_sh1       <= '0;
      r_sh2       <= '0;
      r_sh3       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      if (i_din_valid) begin
        case (r_state)
          HUNT: begin
            if (i_frame_sync) begin
              r_sh0    <= {i_din, r_sh0[WIDTH-1:1]};
              r_sel    <= 2'd1;
              r_idx    <= '0;
              r_locked <= 1'b1;
              r_state  <= RUN;
            end
          end
          RUN: begin
            if (i_frame_sync && !w_frame_start) begin
              // Misplaced sync: drop the partial frame and realign on this bit.
              r_sync_err <= 1'b1;
              r_sh0      <= {i_din, r_sh0[WIDTH-1:1]};
              r_sel      <= 2'd1;
              r_idx      <= '0;
            end else begin
              case (r_sel)
                2'd0:    r_sh0 <= {i_din, r_sh0[WIDTH-1:1]};
                2'd1:    r_sh1 <= {i_din, r_sh1[WIDTH-1:1]};
                2'd2:    r_sh2 <= {i_din, r_sh2[WIDTH-1:1]};
                default: r_sh3 <= (WIDTH-1)'({i_din, r_sh3} >> 1);
              endcase
              if (w_last_bit) begin
                r_out_data  <= {w_ch3_word, r_sh2, r_sh1, r_sh0};
                r_out_valid <= 1'b1;
                r_sel       <= 2'd0;
                r_idx       <= '0;
              end else if (r_sel == 2'd3) begin
                r_sel <= 2'd0;
                r_idx <= r_idx + IDX_W'(1);
              end else begin
                r_sel <= r_sel + 2'd1;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign o_sel       = r_sel;
  assign o_locked    = r_locked;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_sync_err  = r_sync_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with WIDTH=8: alignment, gaps, flywheel,
// mid-frame resync and asynchronous reset.
module tb_tdm_demux;
  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          din;
  logic          din_valid;
  logic          frame_sync;
  logic [1:0]    sel;
  logic          locked;
  logic [4*W-1:0] out_data;
  logic          out_valid;
  logic          sync_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_valid, n_err, valid_k, valid_cyc, first_cyc;

  tdm_demux #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_din(din), .i_din_valid(din_valid),
    .i_frame_sync(frame_sync), .o_sel(sel), .o_locked(locked),
    .o_out_data(out_data), .o_out_valid(out_valid), .o_sync_err(sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0; n_err = 0; valid_k = -1; valid_cyc = -1;
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rise.
  task automatic step(input logic d, input logic v, input logic s);
    @(negedge clk);
    din = d; din_valid = v; frame_sync = s;
    @(posedge clk);
    #1;
    if (out_valid) begin n_valid++; valid_cyc = cyc; end
    if (sync_err) n_err++;
  endtask

  // Send frame bits k0..k1 of data (channel c at data[c*W +: W], LSB first).
  task automatic send_bits(input logic [31:0] data, input int k0, input int k1,
                           input bit sync0, input int gap_pct);
    for (int k = k0; k <= k1; k++) begin
      while (int'($urandom_range(99)) < gap_pct)
        step(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
      step(data[(k % 4) * W + k / 4], 1'b1, sync0 && (k == k0));
      if (out_valid) valid_k = k;
    end
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_locked", 64'(locked), 64'h0);
    chk("rst_sel", 64'(sel), 64'h0);
    chk("rst_sync_err", 64'(sync_err), 64'h0);
    @(negedge clk); rst = 1'b0;

    // Basic aligned frame
    clear_counts();
    send_bits(32'h01FF3CA5, 0, 0, 1'b1, 0);
    chk("sync_sel", 64'(sel), 64'h1);
    chk("sync_locked", 64'(locked), 64'h1);
    send_bits(32'h01FF3CA5, 1, 31, 1'b0, 0);
    chk("f1_nvalid", 64'(n_valid), 64'h1);
    chk("f1_valid_k", 64'(valid_k), 64'd31);
    chk("f1_data", 64'(out_data), 64'h01FF3CA5);
    chk("f1_sel_wrap", 64'(sel), 64'h0);
    step(1'b0, 1'b0, 1'b0);
    chk("f1_valid_pulse", 64'(out_valid), 64'h0);
    chk("f1_data_hold", 64'(out_data), 64'h01FF3CA5);

    // Same frame with ~50% idle gaps; sync lands on the expected start bit
    clear_counts();
    send_bits(32'h01FF3CA5, 0, 31, 1'b1, 50);
    chk("gap_nvalid", 64'(n_valid), 64'h1);
    chk("gap_valid_k", 64'(valid_k), 64'd31);
    chk("gap_nerr", 64'(n_err), 64'h0);
    chk("gap_data", 64'(out_data), 64'h01FF3CA5);

    // Reset, then 40 bits without sync are discarded
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    clear_counts();
    for (int i = 0; i < 40; i++) step(1'($urandom_range(1)), 1'b1, 1'b0);
    chk("hunt_locked", 64'(locked), 64'h0);
    chk("hunt_nvalid", 64'(n_valid), 64'h0);
    chk("hunt_sel", 64'(sel), 64'h0);
    send_bits(32'hDEADBEEF, 0, 31, 1'b1, 0);
    chk("hunt_cap_data", 64'(out_data), 64'hDEADBEEF);
    chk("hunt_cap_nvalid", 64'(n_valid), 64'h1);

    // Back-to-back frames; second has no sync
    clear_counts();
    send_bits(32'h01FF3CA5, 0, 31, 1'b1, 0);
    first_cyc = valid_cyc;
    chk("b2b_a_data", 64'(out_data), 64'h01FF3CA5);
    send_bits(32'h44332211, 0, 31, 1'b0, 0);
    chk("b2b_spacing", 64'(valid_cyc - first_cyc), 64'd32);
    chk("b2b_nvalid", 64'(n_valid), 64'h2);
    chk("b2b_b_data", 64'(out_data), 64'h44332211);

    // Sync injected at bit 13 restarts the frame on that bit
    clear_counts();
    send_bits(32'hCAFEF00D, 0, 12, 1'b1, 0);
    send_bits(32'h87654321, 0, 0, 1'b1, 0);
    chk("mid_err_cnt", 64'(n_err), 64'h1);
    chk("mid_err_pulse", 64'(sync_err), 64'h1);
    chk("mid_data_hold", 64'(out_data), 64'h44332211);
    chk("mid_sel", 64'(sel), 64'h1);
    chk("mid_locked", 64'(locked), 64'h1);
    send_bits(32'h87654321, 1, 31, 1'b0, 0);
    chk("mid_err_once", 64'(n_err), 64'h1);
    chk("mid_nvalid", 64'(n_valid), 64'h1);
    chk("mid_valid_k", 64'(valid_k), 64'd31);
    chk("mid_new_data", 64'(out_data), 64'h87654321);

    // Final bit carrying sync counts as a mid-frame sync
    clear_counts();
    send_bits(32'h01FF3CA5, 0, 30, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1);
    chk("last_sync_err", 64'(sync_err), 64'h1);
    chk("last_sync_novalid", 64'(n_valid), 64'h0);
    chk("last_sync_data", 64'(out_data), 64'h87654321);
    chk("last_sync_sel", 64'(sel), 64'h1);

    // Asynchronous reset at bit 20 of a frame
    clear_counts();
    send_bits(32'h5A5A5A5A, 0, 31, 1'b1, 0);
    send_bits(32'h0F0F0F0F, 0, 19, 1'b0, 0);
    #2; rst = 1'b1; #1;
    chk("arst_out_data", 64'(out_data), 64'h0);
    chk("arst_locked", 64'(locked), 64'h0);
    chk("arst_sel", 64'(sel), 64'h0);
    chk("arst_valid", 64'(out_valid), 64'h0);
    @(negedge clk); rst = 1'b0;
    clear_counts();
    send_bits(32'hFFFFFFFF, 0, 31, 1'b0, 0);
    chk("arst_hunt_locked", 64'(locked), 64'h0);
    chk("arst_hunt_nvalid", 64'(n_valid), 64'h0);
    chk("arst_hunt_data", 64'(out_data), 64'h0);
    send_bits(32'h13579BDF, 0, 31, 1'b1, 0);
    chk("arst_cap_data", 64'(out_data), 64'h13579BDF);
    chk("arst_cap_nvalid", 64'(n_valid), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
